lpgbt_scrambler_param: RTL and testbench

- Parametrised multiplicative (self-synchronising) scrambler/descrambler for lpGBT-style uplink and downlink frames.
- Generalises the fixed 53-bit/order-49 scrambler to any frame width, order and tap.
- Adds a descramble mode, a valid/ready handshake, a runtime seed load and a lock indicator.
- Sits between the frame encoder (or decoder) and the gearbox on the TCLink datapath.

---
 rtl/lpgbt_scrambler_pkg.sv | 21 ++
 rtl/lpgbt_scrambler_core.sv | 32 +++
 rtl/lpgbt_scrambler_param.sv | 150 +++++++++++++++
 tb/tb_lpgbt_scrambler_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lpgbt_scrambler_pkg.sv
// Shared types, default polynomial and helpers for the parametrised
// lpGBT multiplicative scrambler/descrambler.
package lpgbt_scrambler_pkg;

  typedef enum logic [1:0] {
    SEED,
    WARMUP,
    RUN
  } state_e;

  localparam int DEF_ORDER  = 49;
  localparam int DEF_TAP    = 40;
  localparam int DEF_DATA_W = 53;

  localparam logic [DEF_ORDER-1:0] DEF_SEED = 49'h1_6348_aab1_a1a;

  function automatic int lock_frames(input int order, input int width);
    return (order + width - 1) / width;
  endfunction

endpackage

// File: rtl/lpgbt_scrambler_core.sv
// Combinational frame step of the multiplicative scrambler: history and
// frame in, processed frame and next history out.
module lpgbt_scrambler_core #(
  parameter int DATA_W     = 53,
  parameter int ORDER      = 49,
  parameter int TAP        = 40,
  parameter int DESCRAMBLE = 0
) (
  input  logic [ORDER-1:0]  hist_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ORDER-1:0]  hist_o
);

  localparam int EXT_W = ORDER + DATA_W;

  // ext is the virtual stream: history below, this frame above
  logic [EXT_W-1:0] ext;

  always_comb begin
    ext    = {data_i, hist_i};
    data_o = '0;
    for (int k = 0; k < DATA_W; k++) begin
      data_o[k] = data_i[k] ~^ ext[ORDER+k-TAP] ~^ ext[k];
      if (DESCRAMBLE == 0) begin
        ext[ORDER+k] = data_o[k];
      end
    end
    hist_o = ext[EXT_W-1 -: ORDER];
  end

endmodule

// File: rtl/lpgbt_scrambler_param.sv
// Parametrised lpGBT scrambler/descrambler with handshake, seed load and lock.
// Define SCRAMBLER_TMR_EN to triplicate history and state with majority vote.
module lpgbt_scrambler_param
  import lpgbt_scrambler_pkg::*;
#(
  parameter int               DATA_W      = DEF_DATA_W,
  parameter int               ORDER       = DEF_ORDER,
  parameter int               TAP         = DEF_TAP,
  parameter int               DESCRAMBLE  = 0,
  parameter logic [ORDER-1:0] INIT_SEED   = ORDER'(DEF_SEED),
  parameter int               LOCK_FRAMES = lock_frames(ORDER, DATA_W)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bypass,
  input  logic              seed_load,
  input  logic [ORDER-1:0]  seed_value,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked
);

  localparam int              CNT_W   = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FRAMES);

  logic [ORDER-1:0]  hist_v;
  logic [ORDER-1:0]  hist_d;
  logic [ORDER-1:0]  core_hist;
  logic [DATA_W-1:0] core_data;
  state_e            state_v;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              acc;
  logic              adv;

  assign in_ready  = !valid_q || out_ready;
  assign acc       = in_valid && in_ready;
  assign adv       = acc && !bypass;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign locked    = (state_v == RUN) ||
                     (DESCRAMBLE == 0 && state_v == SEED);

  lpgbt_scrambler_core #(
    .DATA_W    (DATA_W),
    .ORDER     (ORDER),
    .TAP       (TAP),
    .DESCRAMBLE(DESCRAMBLE)
  ) u_core (
    .hist_i(hist_v),
    .data_i(in_data),
    .data_o(core_data),
    .hist_o(core_hist)
  );

  always_comb begin
    hist_d  = hist_v;
    state_d = state_v;
    cnt_d   = cnt_q;
    if (adv) begin
      hist_d = core_hist;
      cnt_d  = cnt_inc;
      unique case (state_v)
        SEED:
          state_d = (DESCRAMBLE == 0 || cnt_inc == CNT_MAX)
                    ? RUN : WARMUP;
        WARMUP:
          state_d = (cnt_inc == CNT_MAX) ? RUN : WARMUP;
        RUN:
          state_d = RUN;
        default:
          state_d = SEED;
      endcase
    end
    // seed load wins over the history update of a simultaneous frame
    if (seed_load) begin
      hist_d  = seed_value;
      cnt_d   = '0;
      state_d = SEED;
    end
  end

`ifdef SCRAMBLER_TMR_EN
  logic [ORDER-1:0] hist_q [3];
  state_e           state_q [3];

  assign hist_v = (hist_q[0] & hist_q[1]) |
                  (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);
  assign state_v = state_e'((state_q[0] & state_q[1]) |
                            (state_q[0] & state_q[2]) |
                            (state_q[1] & state_q[2]));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        hist_q[i]  <= INIT_SEED;
        state_q[i] <= SEED;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        hist_q[i]  <= hist_d;
        state_q[i] <= state_d;
      end
    end
  end
`else
  logic [ORDER-1:0] hist_q;
  state_e           state_q;

  assign hist_v  = hist_q;
  assign state_v = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= INIT_SEED;
      state_q <= SEED;
    end else begin
      hist_q  <= hist_d;
      state_q <= state_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (acc) begin
        data_q  <= bypass ? in_data : core_data;
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lpgbt_scrambler_param.sv
// Randomised bench: default scrambler chained into a descrambler, plus a
// 16-bit descrambler, all checked against a bit-stream queue model.
module tb_lpgbt_scrambler_param;

  localparam logic [48:0] INIT = 49'h1_6348_aab1_a1a;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [52:0] scr_id, scr_od, dsc_od;
  logic [48:0] scr_sv, zero_sv;
  logic        scr_iv, scr_irdy, scr_byp, scr_sl, scr_ov, scr_lk;
  logic        dsc_irdy, dsc_ov, dsc_ordy, dsc_lk;
  logic [15:0] d16_id, d16_od;
  logic        d16_iv, d16_irdy, d16_byp, d16_ov, d16_ordy, d16_lk;
  logic        lo;

  int n_chk = 0;
  int n_err = 0;

  logic [48:0] m_scr_h, m_dsc_h, m_d16_h;
  int          m_dsc_cnt, m_d16_cnt;
  logic [52:0] q_scr[$], q_plain[$], q_dsc[$], q_dsc_plain[$];
  bit          q_chk[$], q_dsc_chk[$];
  logic [15:0] q_d16[$];
  bit          cur_chk;

  lpgbt_scrambler_param u_scr (
    .clock(clk), .reset_n(rst_n),
    .in_data(scr_id), .in_valid(scr_iv), .in_ready(scr_irdy),
    .bypass(scr_byp), .seed_load(scr_sl), .seed_value(scr_sv),
    .out_data(scr_od), .out_valid(scr_ov), .out_ready(dsc_irdy),
    .locked(scr_lk)
  );

  lpgbt_scrambler_param #(.DESCRAMBLE(1)) u_dsc (
    .clock(clk), .reset_n(rst_n),
    .in_data(scr_od), .in_valid(scr_ov), .in_ready(dsc_irdy),
    .bypass(lo), .seed_load(lo), .seed_value(zero_sv),
    .out_data(dsc_od), .out_valid(dsc_ov), .out_ready(dsc_ordy),
    .locked(dsc_lk)
  );

  lpgbt_scrambler_param #(.DATA_W(16), .DESCRAMBLE(1)) u_d16 (
    .clock(clk), .reset_n(rst_n),
    .in_data(d16_id), .in_valid(d16_iv), .in_ready(d16_irdy),
    .bypass(d16_byp), .seed_load(lo), .seed_value(zero_sv),
    .out_data(d16_od), .out_valid(d16_ov), .out_ready(d16_ordy),
    .locked(d16_lk)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stream model: s holds bits oldest-first, the newest at the back.
  function automatic logic [52:0] mdl(input logic [48:0] h,
                                      input logic [52:0] d, input int n,
                                      input bit descr,
                                      output logic [48:0] hn);
    bit          s[$];
    bit          yk;
    logic [52:0] y;
    y = '0;
    for (int i = 0; i < 49; i++) s.push_back(h[i]);
    for (int k = 0; k < n; k++) begin
      yk   = d[k] ~^ s[s.size()-40] ~^ s[s.size()-49];
      y[k] = yk;
      s.push_back(descr ? d[k] : yk);
    end
    for (int i = 0; i < 49; i++) hn[i] = s[s.size()-49+i];
    return y;
  endfunction

  function automatic logic [52:0] rnd53();
    return {$urandom(), $urandom()} & {11'h0, {42{1'b1}}} |
           ({21'h0, $urandom()} << 21);
  endfunction

  task automatic model_reset();
    m_scr_h = INIT; m_dsc_h = INIT; m_d16_h = INIT;
    m_dsc_cnt = 0;  m_d16_cnt = 0;
    q_scr.delete(); q_plain.delete(); q_chk.delete();
    q_dsc.delete(); q_dsc_plain.delete(); q_dsc_chk.delete();
    q_d16.delete();
  endtask

  // Called at a negedge with inputs driven; evaluates just before posedge.
  task automatic cycle();
    logic [52:0] y, pl;
    logic [48:0] hn;
    bit          ck;
    #4;
    check("scr_lock", scr_lk, 1'b1);
    check("dsc_lock", dsc_lk, m_dsc_cnt >= 1);
    check("d16_lock", d16_lk, m_d16_cnt >= 4);
    if (dsc_ov && dsc_ordy) begin
      check("dsc_q", q_dsc.size() != 0, 1'b1);
      if (q_dsc.size() != 0) begin
        check("dsc_data", dsc_od, q_dsc.pop_front());
        pl = q_dsc_plain.pop_front();
        if (q_dsc_chk.pop_front()) check("dsc_plain", dsc_od, pl);
      end
    end
    if (scr_ov && dsc_irdy) begin
      check("scr_q", q_scr.size() != 0, 1'b1);
      pl = '0; ck = 1'b0;
      if (q_scr.size() != 0) begin
        check("scr_data", scr_od, q_scr.pop_front());
        pl = q_plain.pop_front();
        ck = q_chk.pop_front();
      end
      y = mdl(m_dsc_h, scr_od, 53, 1'b1, hn);
      m_dsc_h = hn;
      if (m_dsc_cnt < 1) m_dsc_cnt++;
      q_dsc.push_back(y); q_dsc_plain.push_back(pl); q_dsc_chk.push_back(ck);
    end
    if (scr_iv && scr_irdy) begin
      y = mdl(m_scr_h, scr_id, 53, 1'b0, hn);
      if (scr_byp) begin y = scr_id; hn = m_scr_h; end
      q_scr.push_back(y); q_plain.push_back(scr_id); q_chk.push_back(cur_chk);
      m_scr_h = hn;
    end
    if (scr_sl) m_scr_h = scr_sv;
    if (d16_ov && d16_ordy) begin
      check("d16_q", q_d16.size() != 0, 1'b1);
      if (q_d16.size() != 0) check("d16_data", d16_od, q_d16.pop_front());
    end
    if (d16_iv && d16_irdy) begin
      if (d16_byp) q_d16.push_back(d16_id);
      else begin
        y = mdl(m_d16_h, {37'h0, d16_id}, 16, 1'b1, hn);
        q_d16.push_back(y[15:0]);
        m_d16_h = hn;
        if (m_d16_cnt < 4) m_d16_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int nb;
    logic [52:0] held;
    rst_n = 1'b0; lo = 1'b0; zero_sv = '0;
    scr_id = '0; scr_iv = 1'b0; scr_byp = 1'b0; scr_sl = 1'b0; scr_sv = '0;
    d16_id = '0; d16_iv = 1'b0; d16_byp = 1'b0;
    dsc_ordy = 1'b1; d16_ordy = 1'b1; cur_chk = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_scr_ov", scr_ov, 1'b0);
    check("rst_scr_od", scr_od, 53'h0);
    check("rst_scr_lk", scr_lk, 1'b1);
    check("rst_dsc_lk", dsc_lk, 1'b0);
    check("rst_d16_lk", d16_lk, 1'b0);
    rst_n = 1'b1;
    #1 check("rst_irdy", scr_irdy, 1'b1);
    @(negedge clk);

    // zero frames through the golden model, latency check on the first
    scr_iv = 1'b1; scr_id = '0;
    check("lat_pre", scr_ov, 1'b0);
    cycle();
    check("lat_post", scr_ov, 1'b1);
    repeat (3) cycle();

    // random frames; descrambler must return plaintext from frame 2
    for (int i = 0; i < 20; i++) begin
      scr_id = rnd53(); cur_chk = (i >= 1);
      cycle();
    end
    cur_chk = 1'b0;

    // backpressure: nothing moves while dsc output is stalled
    dsc_ordy = 1'b0;
    held = dsc_od;
    for (int i = 0; i < 5; i++) begin
      scr_id = rnd53();
      cycle();
      check("bp_irdy", scr_irdy, 1'b0);
      check("bp_ov", dsc_ov, 1'b1);
      check("bp_hold", dsc_od, held);
    end
    dsc_ordy = 1'b1;
    repeat (3) begin scr_id = rnd53(); cycle(); end

    // seed load to zero alongside an accept, then a zero frame
    scr_id = rnd53(); scr_sl = 1'b1; scr_sv = '0;
    cycle();
    scr_sl = 1'b0; scr_id = '0;
    cycle();
    check("seed_zero_ov", scr_ov, 1'b1);
    check("seed_zero_od", scr_od, 53'h0);
    for (int i = 0; i < 8; i++) begin
      scr_id = rnd53(); dsc_ordy = 1'($urandom_range(0, 1));
      cycle();
    end
    dsc_ordy = 1'b1; scr_iv = 1'b0;
    repeat (3) cycle();

    // 16-bit descrambler: bypass frames do not count toward lock
    nb = 0;
    d16_iv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      d16_byp = (i == 1 || i == 3);
      d16_id = 16'($urandom());
      if (!d16_byp) nb++;
      cycle();
      check("d16_lock_seq", d16_lk, nb >= 4);
    end
    d16_iv = 1'b0; d16_byp = 1'b0;
    repeat (2) cycle();

    // asynchronous reset between clock edges mid-stream
    scr_iv = 1'b1; d16_iv = 1'b1;
    repeat (3) begin scr_id = rnd53(); d16_id = 16'($urandom()); cycle(); end
    #2 rst_n = 1'b0;
    #1;
    check("mid_scr_ov", scr_ov, 1'b0);
    check("mid_dsc_ov", dsc_ov, 1'b0);
    check("mid_d16_ov", d16_ov, 1'b0);
    check("mid_scr_lk", scr_lk, 1'b1);
    check("mid_dsc_lk", dsc_lk, 1'b0);
    check("mid_d16_lk", d16_lk, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin scr_id = rnd53(); d16_id = 16'($urandom()); cycle(); end
    scr_iv = 1'b0; d16_iv = 1'b0;
    repeat (4) cycle();
    check("drain_scr", q_scr.size(), 0);
    check("drain_dsc", q_dsc.size(), 0);
    check("drain_d16", q_d16.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
